// File: rtl/bias_stream_gen_pkg.sv
// Shared definitions for the bias coefficient streamer: widths, per-layer channel counts,
// replay-order and FSM encodings, and a width helper.
package bias_stream_gen_pkg;

  localparam int COEFF_WIDTH    = 16;
  localparam int KERN_S_K_CONV1 = 32;

  typedef enum logic [0:0] {
    ORDER_FRAME   = 1'b0,
    ORDER_CHANNEL = 1'b1
  } order_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bias_stream_gen_rom.sv
// Coefficient ROM with a one-cycle registered read. Contents arrive as a packed
// parameter with word 0 in the least significant bits.
module bias_stream_gen_rom
  import bias_stream_gen_pkg::*;
#(
  parameter int                             MEM_SIZE   = KERN_S_K_CONV1,
  parameter int                             DATA_WIDTH = COEFF_WIDTH,
  parameter logic [MEM_SIZE*DATA_WIDTH-1:0] INIT_DATA  = '0
) (
  input  logic                              clk,
  input  logic                              ce,
  input  logic [clog2_min1(MEM_SIZE)-1:0]   addr,
  output logic [DATA_WIDTH-1:0]             q
);

  localparam int ADDR_W = clog2_min1(MEM_SIZE);

  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (a == ADDR_W'(i)) w = INIT_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (ce) q <= rom_word(addr);
  end

endmodule

// File: rtl/bias_stream_gen.sv
// Streams N_CH bias words, replayed N_REPEAT times, from the ROM onto an ap_fifo output,
// with start/idle/done handshake and a 2-entry skid buffer covering the ROM latency.
module bias_stream_gen
  import bias_stream_gen_pkg::*;
#(
  parameter int                       DATA_W    = COEFF_WIDTH,
  parameter int                       N_CH      = KERN_S_K_CONV1,
  parameter int                       N_REPEAT  = 1,
  parameter int                       ORDER     = 0,
  parameter logic [N_CH*DATA_W-1:0]   INIT_DATA = '0
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  output logic [DATA_W-1:0] output_V_din,
  input  logic              output_V_full_n,
  output logic              output_V_write
);

  localparam int TOTAL = N_CH * N_REPEAT;
  localparam int CH_W  = clog2_min1(N_CH);
  localparam int REP_W = clog2_min1(N_REPEAT + 1);
  localparam int CNT_W = clog2_min1(TOTAL + 1);

  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(N_REPEAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL);

  state_e            state_q;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0]  iss_cnt_q, wr_cnt_q;
  logic              rom_vld_q;
  logic [1:0]        fifo_cnt_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem_q [2];
  logic              ap_idle_q, ap_done_q;

  logic [DATA_W-1:0] rom_q;
  logic              issue, push, pop, last_wr;
  logic [2:0]        occ;

  // Issue control: occupancy counts the word in the ROM register and excludes the one leaving now.
  assign pop     = (fifo_cnt_q != 2'd0) & output_V_full_n;
  assign push    = rom_vld_q;
  assign occ     = 3'(fifo_cnt_q) + 3'(rom_vld_q) - 3'(pop);
  assign issue   = (state_q == ST_RUN) && (iss_cnt_q != CNT_TOTAL) && (occ < 3'd2);
  assign last_wr = pop && (wr_cnt_q == CNT_LAST);

  // The final issue leaves the counters parked on a valid address.
  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    rep_cnt_d = rep_cnt_q;
    if (issue && (iss_cnt_q != CNT_LAST)) begin
      if (ORDER == int'(ORDER_CHANNEL)) begin
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          ch_cnt_d  = ch_cnt_q + 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else begin
        if (ch_cnt_q == CH_LAST) begin
          ch_cnt_d  = '0;
          rep_cnt_d = rep_cnt_q + 1'b1;
        end else begin
          ch_cnt_d = ch_cnt_q + 1'b1;
        end
      end
    end
  end

  bias_stream_gen_rom #(
    .MEM_SIZE   (N_CH),
    .DATA_WIDTH (DATA_W),
    .INIT_DATA  (INIT_DATA)
  ) u_rom (
    .clk  (ap_clk),
    .ce   (issue),
    .addr (ch_cnt_q),
    .q    (rom_q)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_IDLE;
      ch_cnt_q   <= '0;
      rep_cnt_q  <= '0;
      iss_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      rom_vld_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ap_idle_q  <= 1'b1;
      ap_done_q  <= 1'b0;
    end else begin
      rom_vld_q <= issue;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 2'd1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 2'd1;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      ap_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            state_q   <= ST_RUN;
            ap_idle_q <= 1'b0;
            ch_cnt_q  <= '0;
            rep_cnt_q <= '0;
            iss_cnt_q <= '0;
            wr_cnt_q  <= '0;
          end
        end
        ST_RUN: begin
          ch_cnt_q  <= ch_cnt_d;
          rep_cnt_q <= rep_cnt_d;
          if (issue) iss_cnt_q <= iss_cnt_q + 1'b1;
          if (pop)   wr_cnt_q  <= wr_cnt_q + 1'b1;
          if (last_wr) begin
            state_q   <= ST_DONE;
            ap_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          ap_idle_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_IDLE;
          ap_idle_q <= 1'b1;
        end
      endcase
    end
  end

  // Skid storage holds data only; emptiness is tracked by the reset control above.
  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rom_q;
  end

  assign output_V_write = pop;
  assign output_V_din   = (fifo_cnt_q != 2'd0) ? fifo_mem_q[rd_ptr_q] : '0;
  assign ap_idle        = ap_idle_q;
  assign ap_done        = ap_done_q;

endmodule

// File: tb/tb_bias_stream_gen.sv
// Directed bench for bias_stream_gen: frame/channel-major replay, back-pressure,
// held start, asynchronous reset mid-run and a single-word configuration.
module tb_bias_stream_gen;

  localparam logic [63:0] ROM4 = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
  localparam logic [15:0] ROM1 = 16'h0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start;
  logic [2:0]  full_n;
  wire  [2:0]  idle, done, wr;
  wire  [15:0] din0, din1, din2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [1:0]  act = 2'd0;
  int          fn_mode = 0;
  logic [15:0] got [$];
  int          first_wr_cyc, done_cyc, done_cnt;
  int          s;

  logic [15:0] EXP_FM [12] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044,
                               16'h0011, 16'h0022, 16'h0033, 16'h0044,
                               16'h0011, 16'h0022, 16'h0033, 16'h0044};
  logic [15:0] EXP_CM [12] = '{16'h0011, 16'h0011, 16'h0011, 16'h0022,
                               16'h0022, 16'h0022, 16'h0033, 16'h0033,
                               16'h0033, 16'h0044, 16'h0044, 16'h0044};

  bias_stream_gen #(.DATA_W(16), .N_CH(4), .N_REPEAT(3), .ORDER(0), .INIT_DATA(ROM4)) dut0 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start[0]), .ap_idle(idle[0]), .ap_done(done[0]),
    .output_V_din(din0), .output_V_full_n(full_n[0]), .output_V_write(wr[0]));

  bias_stream_gen #(.DATA_W(16), .N_CH(4), .N_REPEAT(3), .ORDER(1), .INIT_DATA(ROM4)) dut1 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start[1]), .ap_idle(idle[1]), .ap_done(done[1]),
    .output_V_din(din1), .output_V_full_n(full_n[1]), .output_V_write(wr[1]));

  bias_stream_gen #(.DATA_W(16), .N_CH(1), .N_REPEAT(1), .ORDER(0), .INIT_DATA(ROM1)) dut2 (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start[2]), .ap_idle(idle[2]), .ap_done(done[2]),
    .output_V_din(din2), .output_V_full_n(full_n[2]), .output_V_write(wr[2]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic        a_wr, a_fn, a_done;
    logic [15:0] a_din;
    a_wr   = wr[act];
    a_fn   = full_n[act];
    a_done = done[act];
    a_din  = (act == 2'd0) ? din0 : (act == 2'd1) ? din1 : din2;
    if (!a_fn) check_val("wr_while_full", {31'd0, a_wr}, 32'd0);
    if (a_wr) begin
      if (got.size() == 0) first_wr_cyc = cyc;
      got.push_back(a_din);
    end
    if (a_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dut2.u_rom.ce) check_val("rom_addr_n1", {31'd0, dut2.u_rom.addr}, 32'd0);
  end

  always @(posedge clk) begin
    #1;
    full_n = 3'b111;
    if (fn_mode == 1)      full_n[act] = 1'($urandom_range(0, 1));
    else if (fn_mode == 2) full_n[act] = 1'b0;
  end

  task automatic clear_cap();
    got.delete();
    first_wr_cyc = -1;
    done_cyc     = -1;
    done_cnt     = 0;
  endtask

  task automatic pulse_start(input logic [1:0] k, output int s_cyc);
    @(posedge clk); #1;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt < target) check_val("done_timeout", done_cnt, target);
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (got.size() < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (got.size() < target) check_val("words_timeout", got.size(), target);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [15:0] exp_t [12]);
    check_val({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check_val(tag, got[i], exp_t[i % 12]);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    void'($urandom(32'd1234));
    rst    = 1'b1;
    start  = 3'b000;
    full_n = 3'b111;
    clear_cap();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_idle",  {31'd0, idle[0]}, 32'd1);
    check_val("rst_done",  {31'd0, done[0]}, 32'd0);
    check_val("rst_write", {31'd0, wr[0]},   32'd0);
    check_val("rst_din",   {16'd0, din0},    32'd0);
    #2 rst = 1'b0;

    // T1: frame-major
    act = 2'd0; clear_cap();
    pulse_start(2'd0, s);
    @(negedge clk);
    check_val("t1_idle_run", {31'd0, idle[0]}, 32'd0);
    wait_done(1, 100);
    check_val("t1_first_wr", first_wr_cyc, s + 2);
    check_val("t1_done_cyc", done_cyc, s + 14);
    idle_cycles(3);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_idle_back", {31'd0, idle[0]}, 32'd1);
    check_seq("t1_data", 12, EXP_FM);

    // T2: channel-major
    act = 2'd1; clear_cap();
    pulse_start(2'd1, s);
    wait_done(1, 100);
    check_val("t2_done_cyc", done_cyc, s + 14);
    idle_cycles(3);
    check_val("t2_done_cnt", done_cnt, 1);
    check_seq("t2_data", 12, EXP_CM);

    // T3: random back-pressure with a 20-cycle stall mid-run
    act = 2'd0; clear_cap();
    fn_mode = 1;
    pulse_start(2'd0, s);
    wait_words(4, 200);
    fn_mode = 2;
    repeat (20) @(negedge clk);
    fn_mode = 1;
    wait_done(1, 400);
    fn_mode = 0;
    idle_cycles(3);
    check_val("t3_done_cnt", done_cnt, 1);
    check_seq("t3_data", 12, EXP_FM);

    // T4: start held high across two runs
    act = 2'd0; clear_cap();
    @(posedge clk); #1;
    start[0] = 1'b1;
    wait_done(2, 200);
    start[0] = 1'b0;
    idle_cycles(20);
    check_val("t4_done_cnt", done_cnt, 2);
    check_val("t4_idle", {31'd0, idle[0]}, 32'd1);
    check_seq("t4_data", 24, EXP_FM);

    // T5: asynchronous reset after the fifth write
    act = 2'd0; clear_cap();
    pulse_start(2'd0, s);
    wait_words(5, 100);
    #2 rst = 1'b1;
    #1;
    check_val("t5_rst_idle",  {31'd0, idle[0]}, 32'd1);
    check_val("t5_rst_write", {31'd0, wr[0]},   32'd0);
    check_val("t5_rst_din",   {16'd0, din0},    32'd0);
    check_val("t5_rst_done",  {31'd0, done[0]}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    idle_cycles(20);
    check_val("t5_no_done", done_cnt, 0);
    clear_cap();
    pulse_start(2'd0, s);
    wait_done(1, 100);
    idle_cycles(3);
    check_val("t5_done_cnt", done_cnt, 1);
    check_seq("t5_data", 12, EXP_FM);

    // T6: single-word configuration
    act = 2'd2; clear_cap();
    pulse_start(2'd2, s);
    wait_done(1, 50);
    check_val("t6_first_wr", first_wr_cyc, s + 2);
    check_val("t6_done_cyc", done_cyc, s + 3);
    idle_cycles(5);
    check_val("t6_done_cnt", done_cnt, 1);
    check_val("t6_idle", {31'd0, idle[2]}, 32'd1);
    check_seq("t6_data", 1, EXP_FM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected completion");
    $fatal(1, "watchdog");
  end

endmodule
